// File: rtl/mod_reducer.sv
// mod_reducer: sequential restoring shift-subtract reduction R = P mod M.
// Consumes the 2*WIDTH-bit product of the upstream multiplier one bit per
// cycle; defining MOD_REDUCER_RADIX4_EN consumes two bits per cycle instead.
module mod_reducer #(
  parameter int unsigned WIDTH = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] P,
  input  logic [WIDTH-1:0]   M,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   R,
  output logic               err
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    preg;
  logic [WIDTH-1:0] mreg;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_next;

  // One restoring step: shift in a bit, subtract the modulus if it fits.
  // The result is always below m, so it fits back into WIDTH bits.
  function automatic logic [WIDTH-1:0] cond_sub(
    input logic [WIDTH-1:0] a,
    input logic             b,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH:0] t;
    t = {a, b};
    if (t >= {1'b0, m}) begin
      cond_sub = WIDTH'(t - {1'b0, m});
    end else begin
      cond_sub = WIDTH'(t);
    end
  endfunction

`ifdef MOD_REDUCER_RADIX4_EN
  localparam logic [CW-1:0] CNT_INIT = CW'(PW - 2);
  localparam logic [CW-1:0] CNT_STEP = CW'(2);

  // Two chained steps per cycle; cnt marks the lower bit of the pair.
  always_comb begin
    acc_next = cond_sub(cond_sub(acc, preg[CW'(cnt + CW'(1))], mreg),
                        preg[cnt], mreg);
  end
`else
  localparam logic [CW-1:0] CNT_INIT = CW'(PW - 1);
  localparam logic [CW-1:0] CNT_STEP = CW'(1);

  // Single step per cycle on bit cnt.
  always_comb begin
    acc_next = cond_sub(acc, preg[cnt], mreg);
  end
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      preg  <= '0;
      mreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      R     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            preg <= P;
            mreg <= M;
            acc  <= '0;
            cnt  <= CNT_INIT;
            busy <= 1'b1;
            if (M == '0) begin
              state <= DONE;
              R     <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          if (cnt == '0) begin
            state <= DONE;
            R     <= acc_next;
            err   <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_STEP;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reducer.sv
// tb_mod_reducer: directed self-checking bench for mod_reducer (WIDTH=256).
module tb_mod_reducer;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned PW    = 2 * WIDTH;
`ifdef MOD_REDUCER_RADIX4_EN
  localparam int LAT = WIDTH;
`else
  localparam int LAT = PW;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [PW-1:0]    P = '0;
  logic [WIDTH-1:0] M = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic             err;

  int errors = 0;
  int checks = 0;

  mod_reducer #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .P(P),
    .M(M),
    .busy(busy),
    .done(done),
    .R(R),
    .err(err)
  );

  always #5 clock = ~clock;

  // Advance one edge and sample 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; optionally re-pulse start at cycle glitch_at of RUN.
  task automatic run_op(input logic [PW-1:0] p_in, input logic [WIDTH-1:0] m_in,
                        input int glitch_at, output int n, output bit busy_ok);
    P = p_in;
    M = m_in;
    start = 1'b1;
    tick();
    start = 1'b0;
    P = '1;
    M = WIDTH'(3);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < LAT + 20) begin
      if (!busy) busy_ok = 1'b0;
      start = (n == glitch_at);
      if (n == glitch_at) P = PW'(2000);
      tick();
      start = 1'b0;
      n++;
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  // Run an operation and compare latency, R and err; then check the pulse ends.
  task automatic do_op(input string tag, input logic [PW-1:0] p_in, input logic [WIDTH-1:0] m_in,
                       input logic [WIDTH-1:0] r_exp, input logic e_exp, input int lat_exp,
                       input int glitch_at);
    int n;
    bit bok;
    run_op(p_in, m_in, glitch_at, n, bok);
    check({tag, "_latency"}, PW'(n), PW'(lat_exp));
    check({tag, "_R"}, PW'(R), PW'(r_exp));
    check({tag, "_err"}, PW'(err), PW'(e_exp));
    check({tag, "_busy_held"}, PW'(bok), PW'(1));
    tick();
    check({tag, "_done_drop"}, PW'(done), PW'(0));
    check({tag, "_busy_drop"}, PW'(busy), PW'(0));
  endtask

  initial begin
    logic [PW-1:0]    p_big;
    logic [WIDTH-1:0] m_big;
    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    int n1;
    int n2;
    bit seen;

    // Reset state.
    reset = 1'b0;
    repeat (3) tick();
    check("rst_busy", PW'(busy), PW'(0));
    check("rst_done", PW'(done), PW'(0));
    check("rst_R", PW'(R), PW'(0));
    check("rst_err", PW'(err), PW'(0));
    reset = 1'b1;
    tick();

    // Basic operation.
    do_op("basic", PW'(1000), WIDTH'(7), WIDTH'(6), 1'b0, LAT, -1);

    // Reset in the middle of RUN discards the operation.
    P = PW'(1000);
    M = WIDTH'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    reset = 1'b0;
    tick();
    check("midrst_busy", PW'(busy), PW'(0));
    check("midrst_done", PW'(done), PW'(0));
    check("midrst_R", PW'(R), PW'(0));
    reset = 1'b1;
    seen = 1'b0;
    repeat (LAT + 20) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", PW'(seen), PW'(0));

    // Power of two: 2^511 mod (2^256-1) = 2^255.
    p_big = PW'(1) << 511;
    m_big = '1;
    do_op("pow2", p_big, m_big, WIDTH'(1) << 255, 1'b0, LAT, -1);

    // Maximum product reduces to zero.
    p_big = PW'(m_big) * PW'(m_big);
    do_op("maxprod", p_big, m_big, WIDTH'(0), 1'b0, LAT, -1);

    // P < M, then zero modulus right after a nonzero result.
    do_op("p_lt_m", PW'(5), WIDTH'(9), WIDTH'(5), 1'b0, LAT, -1);
    do_op("mzero", PW'(12345), WIDTH'(0), WIDTH'(0), 1'b1, 0, -1);
    do_op("after_mzero", PW'(10), WIDTH'(3), WIDTH'(1), 1'b0, LAT, -1);

    // P == 0 and M == 1.
    do_op("p_zero", PW'(0), WIDTH'(13), WIDTH'(0), 1'b0, LAT, -1);
    do_op("m_one", PW'(999), WIDTH'(1), WIDTH'(0), 1'b0, LAT, -1);

    // start pulsed during RUN is ignored.
    do_op("ignore_start", PW'(1000), WIDTH'(7), WIDTH'(6), 1'b0, LAT, 50);

    // start held high: operations repeat every LAT+2 cycles.
    P = PW'(100);
    M = WIDTH'(7);
    start = 1'b1;
    n1 = 0;
    while (!done && n1 < LAT + 20) begin
      tick();
      n1++;
    end
    n2 = 0;
    tick();
    n2++;
    while (!done && n2 < LAT + 20) begin
      tick();
      n2++;
    end
    check("hold_spacing", PW'(n2), PW'(LAT + 2));
    check("hold_R", PW'(R), PW'(2));
    start = 1'b0;
    n1 = 0;
    while (busy && n1 < LAT + 20) begin
      tick();
      n1++;
    end
    check("hold_idle", PW'(busy), PW'(0));

    // Multiplier-product vectors against an independent % model.
    m_big = (WIDTH'(1) << 255) + WIDTH'(95);
    a_k = {8{32'hDEADBEEF}};
    b_k = {8{32'h0F1E2D3C}} ^ (WIDTH'(1) << 200);
    p_big = PW'(a_k) * PW'(b_k);
    do_op("kara0", p_big, m_big, WIDTH'(p_big % PW'(m_big)), 1'b0, LAT, -1);
    a_k = '1;
    b_k = {4{64'h0123456789ABCDEF}};
    p_big = PW'(a_k) * PW'(b_k);
    do_op("kara1", p_big, m_big, WIDTH'(p_big % PW'(m_big)), 1'b0, LAT, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
